// File: rtl/prefix_subtractor_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor (Diff = A + ~B + 1) with valid/ready on both sides.
// Stage 1 forms bitwise g/p, stage 2 runs the first SPLIT prefix levels, stage 3 finishes and forms outputs.
module prefix_subtractor_pipe #(
    parameter int W     = 8,
    parameter int SPLIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Diff,
    output logic         Borrow,
    output logic         Ovf,
    output logic [W-1:0] Cg
);

    localparam int LVLS = $clog2(W);

    logic         rdy_q;
    logic         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic         en1, en2, en3, fire_in;

    logic [W-1:0] g1_q, g1_d, p1_q, p1_d, ps1_q, ps1_d;
    logic         sa1_q, sa1_d, sb1_q, sb1_d;

    logic [W-1:0] g2_q, g2_d, p2_q, p2_d, ps2_q, ps2_d;
    logic         sa2_q, sa2_d, sb2_q, sb2_d;

    logic [W-1:0] diff_q, diff_d, cg_q, cg_d;
    logic         borrow_q, borrow_d, ovf_q, ovf_d;

    logic [W-1:0] nb, p_raw, g_raw;
    logic [W-1:0] g2_net, p2_net, pmask2;
    logic [W-1:0] g3_net, p3_net, pmask3;

    // Stall chain: a stage may load when it is empty or its successor loads this cycle.
    always_comb begin
        en3      = ~v3_q | out_ready;
        en2      = ~v2_q | en3;
        en1      = ~v1_q | en2;
        in_ready = rdy_q & en1;
        fire_in  = in_valid & in_ready;
    end

    // Stage 1: bitwise generate/propagate of A + ~B, carry-in folded into bit 0.
    always_comb begin
        nb    = ~B;
        p_raw = A ^ nb;
        g_raw = A & nb;

        v1_d  = en1 ? fire_in : v1_q;
        g1_d  = g1_q;
        p1_d  = p1_q;
        ps1_d = ps1_q;
        sa1_d = sa1_q;
        sb1_d = sb1_q;
        if (fire_in) begin
            g1_d  = {g_raw[W-1:1], g_raw[0] | p_raw[0]};
            p1_d  = {p_raw[W-1:1], 1'b0};
            ps1_d = p_raw;
            sa1_d = A[W-1];
            sb1_d = B[W-1];
        end
    end

    // Stage 2: prefix levels 0..SPLIT-1; positions below the span distance pass through.
    always_comb begin
        g2_net = g1_q;
        p2_net = p1_q;
        pmask2 = '0;
        for (int l = 0; l < SPLIT; l++) begin
            pmask2 = (W'(1) << (1 << l)) - W'(1);
            g2_net = g2_net | (p2_net & (g2_net << (1 << l)));
            p2_net = p2_net & ((p2_net << (1 << l)) | pmask2);
        end

        v2_d  = en2 ? v1_q : v2_q;
        g2_d  = g2_q;
        p2_d  = p2_q;
        ps2_d = ps2_q;
        sa2_d = sa2_q;
        sb2_d = sb2_q;
        if (en2 && v1_q) begin
            g2_d  = g2_net;
            p2_d  = p2_net;
            ps2_d = ps1_q;
            sa2_d = sa1_q;
            sb2_d = sb1_q;
        end
    end

    // Stage 3: remaining prefix levels, then sum, borrow and signed overflow.
    always_comb begin
        g3_net = g2_q;
        p3_net = p2_q;
        pmask3 = '0;
        for (int l = SPLIT; l < LVLS; l++) begin
            pmask3 = (W'(1) << (1 << l)) - W'(1);
            g3_net = g3_net | (p3_net & (g3_net << (1 << l)));
            p3_net = p3_net & ((p3_net << (1 << l)) | pmask3);
        end

        v3_d     = en3 ? v2_q : v3_q;
        diff_d   = diff_q;
        cg_d     = cg_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        if (en3 && v2_q) begin
            diff_d   = ps2_q ^ {g3_net[W-2:0], 1'b1};
            cg_d     = g3_net;
            borrow_d = ~g3_net[W-1];
            ovf_d    = (sa2_q ^ sb2_q) & (sa2_q ^ diff_d[W-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            g1_q     <= '0;
            p1_q     <= '0;
            ps1_q    <= '0;
            sa1_q    <= 1'b0;
            sb1_q    <= 1'b0;
            g2_q     <= '0;
            p2_q     <= '0;
            ps2_q    <= '0;
            sa2_q    <= 1'b0;
            sb2_q    <= 1'b0;
            diff_q   <= '0;
            cg_q     <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rdy_q    <= 1'b1;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            g1_q     <= g1_d;
            p1_q     <= p1_d;
            ps1_q    <= ps1_d;
            sa1_q    <= sa1_d;
            sb1_q    <= sb1_d;
            g2_q     <= g2_d;
            p2_q     <= p2_d;
            ps2_q    <= ps2_d;
            sa2_q    <= sa2_d;
            sb2_q    <= sb2_d;
            diff_q   <= diff_d;
            cg_q     <= cg_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = v3_q;
    assign Diff      = diff_q;
    assign Cg        = cg_q;
    assign Borrow    = borrow_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Bench for prefix_subtractor_pipe: directed vector table, handshake corner sequences,
// and randomized traffic on W=8 and W=16 instances checked against an arithmetic model.
module tb_prefix_subtractor_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, Borrow8, Ovf8;
    logic [7:0]  A8, B8, Diff8, Cg8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, Borrow16, Ovf16;
    logic [15:0] A16, B16, Diff16, Cg16;

    prefix_subtractor_pipe #(.W(8), .SPLIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .A(A8), .B(B8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .Diff(Diff8), .Borrow(Borrow8), .Ovf(Ovf8), .Cg(Cg8)
    );

    prefix_subtractor_pipe #(.W(16), .SPLIT(3)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .A(A16), .B(B16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .Diff(Diff16), .Borrow(Borrow16), .Ovf(Ovf16), .Cg(Cg16)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic [15:0] cg;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic [7:0] cg;
    } vec_t;

    res_t q8[$];
    res_t q16[$];
    res_t e8, e16;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b);
        res_t r;
        int ia, ib, mask, half, sa, sb, sd, m;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        ia   = int'(a) & mask;
        ib   = int'(b) & mask;
        r.d  = 16'((ia - ib) & mask);
        r.bo = (ia < ib);
        sa   = (ia >= half) ? ia - (1 << w) : ia;
        sb   = (ib >= half) ? ib - (1 << w) : ib;
        sd   = sa - sb;
        r.ov = (sd < -half) || (sd >= half);
        r.cg = '0;
        for (int i = 0; i < w; i++) begin
            m = (1 << (i + 1)) - 1;
            r.cg[i] = ((((ia & m) + ((~ib) & m) + 1) >> (i + 1)) % 2) != 0;
        end
        return r;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int last8 = -10;
    int run8 = 0;

    // Scoreboards: every accepted operand pair must come out once, in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
        end else begin
            if (out_valid8 && out_ready8) begin
                if (last8 == cyc - 1) run8 = run8 + 1;
                else run8 = 1;
                last8 = cyc;
                if (q8.size() == 0) begin
                    chk("w8_unexpected_out", 32'(out_valid8), 32'(0));
                end else begin
                    e8 = q8.pop_front();
                    chk("w8_diff", 32'(Diff8), 32'(e8.d[7:0]));
                    chk("w8_borrow", 32'(Borrow8), 32'(e8.bo));
                    chk("w8_ovf", 32'(Ovf8), 32'(e8.ov));
                    chk("w8_cg", 32'(Cg8), 32'(e8.cg[7:0]));
                end
            end
            if (in_valid8 && in_ready8) q8.push_back(model(8, {8'h00, A8}, {8'h00, B8}));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
        end else begin
            if (out_valid16 && out_ready16) begin
                if (q16.size() == 0) begin
                    chk("w16_unexpected_out", 32'(out_valid16), 32'(0));
                end else begin
                    e16 = q16.pop_front();
                    chk("w16_diff", 32'(Diff16), 32'(e16.d));
                    chk("w16_borrow", 32'(Borrow16), 32'(e16.bo));
                    chk("w16_ovf", 32'(Ovf16), 32'(e16.ov));
                    chk("w16_cg", 32'(Cg16), 32'(e16.cg));
                end
            end
            if (in_valid16 && in_ready16) q16.push_back(model(16, A16, B16));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[7];
    int   acc;
    logic seen;
    logic [7:0] hold_d, hold_cg;
    logic hold_bo;
    logic f8, f16;

    initial begin
        tbl[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0, cg: 8'hFD};
        tbl[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1, ov: 1'b0, cg: 8'h03};
        tbl[2] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1, cg: 8'h80};
        tbl[3] = '{a: 8'h00, b: 8'h00, d: 8'h00, bo: 1'b0, ov: 1'b0, cg: 8'hFF};
        tbl[4] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0, cg: 8'hFF};
        tbl[5] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1, cg: 8'h7F};
        tbl[6] = '{a: 8'h10, b: 8'h20, d: 8'hF0, bo: 1'b1, ov: 1'b0, cg: 8'h1F};

        in_valid8 = 1'b0; out_ready8 = 1'b1; A8 = '0; B8 = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; A16 = '0; B16 = '0;

        rst_n = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid8), 32'(0));
        chk("rst_diff", 32'(Diff8), 32'(0));
        chk("rst_borrow", 32'(Borrow8), 32'(0));
        chk("rst_ovf", 32'(Ovf8), 32'(0));
        chk("rst_cg", 32'(Cg8), 32'(0));
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready8), 32'(1));

        // Single operations: exact 3-clock latency and result fields.
        for (int k = 0; k < 7; k++) begin
            A8 = tbl[k].a;
            B8 = tbl[k].b;
            in_valid8 = 1'b1;
            @(negedge clk);
            chk("tbl_in_ready", 32'(in_ready8), 32'(1));
            step();
            in_valid8 = 1'b0;
            @(negedge clk);
            chk("tbl_lat1", 32'(out_valid8), 32'(0));
            @(negedge clk);
            chk("tbl_lat2", 32'(out_valid8), 32'(0));
            @(negedge clk);
            chk("tbl_lat3", 32'(out_valid8), 32'(1));
            chk("tbl_diff", 32'(Diff8), 32'(tbl[k].d));
            chk("tbl_borrow", 32'(Borrow8), 32'(tbl[k].bo));
            chk("tbl_ovf", 32'(Ovf8), 32'(tbl[k].ov));
            chk("tbl_cg", 32'(Cg8), 32'(tbl[k].cg));
            step();
        end
        repeat (3) step();

        // Ten back-to-back operations must emerge on ten consecutive cycles.
        in_valid8 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            A8 = 8'($urandom);
            B8 = 8'($urandom);
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready8), 32'(1));
            step();
        end
        in_valid8 = 1'b0;
        repeat (5) step();
        chk("stream_consecutive", 32'(run8), 32'(10));
        chk("stream_drained", 32'(q8.size()), 32'(0));

        // Back-pressure: three accepts fill the pipe, outputs hold, release drains and accepts together.
        out_ready8 = 1'b0;
        in_valid8 = 1'b1;
        A8 = 8'($urandom);
        B8 = 8'($urandom);
        acc = 0;
        seen = 1'b0;
        hold_d = '0; hold_cg = '0; hold_bo = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            f8 = in_ready8;
            if (f8) acc++;
            if (out_valid8) begin
                if (!seen) begin
                    seen = 1'b1;
                    hold_d = Diff8; hold_cg = Cg8; hold_bo = Borrow8;
                end else begin
                    chk("stall_diff_stable", 32'(Diff8), 32'(hold_d));
                    chk("stall_cg_stable", 32'(Cg8), 32'(hold_cg));
                    chk("stall_borrow_stable", 32'(Borrow8), 32'(hold_bo));
                end
            end
            step();
            if (f8) begin
                A8 = 8'($urandom);
                B8 = 8'($urandom);
            end
        end
        chk("stall_accepts", 32'(acc), 32'(3));
        chk("stall_in_ready", 32'(in_ready8), 32'(0));
        chk("stall_out_valid", 32'(out_valid8), 32'(1));
        out_ready8 = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready8), 32'(1));
        step();
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("release_still_full", 32'(out_valid8), 32'(1));
        repeat (6) step();
        chk("release_drained", 32'(q8.size()), 32'(0));

        // Reset with two operations in flight: nothing from them may appear.
        in_valid8 = 1'b1;
        A8 = 8'h44; B8 = 8'h11;
        step();
        A8 = 8'h22; B8 = 8'h99;
        step();
        in_valid8 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid8), 32'(0));
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_no_ghost", 32'(out_valid8), 32'(0));
        end
        step();

        // Random traffic on both widths with random source and sink stalls.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            f8 = in_valid8 & in_ready8;
            f16 = in_valid16 & in_ready16;
            @(posedge clk);
            #1;
            if (!in_valid8 || f8) begin
                in_valid8 = ($urandom_range(0, 3) != 0);
                A8 = 8'($urandom);
                B8 = 8'($urandom);
            end
            if (!in_valid16 || f16) begin
                in_valid16 = ($urandom_range(0, 3) != 0);
                A16 = 16'($urandom);
                B16 = 16'($urandom);
            end
            out_ready8 = ($urandom_range(0, 3) != 0);
            out_ready16 = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_valid16 = 1'b0;
        out_ready8 = 1'b1;
        out_ready16 = 1'b1;
        repeat (10) step();
        chk("rand_w8_drained", 32'(q8.size()), 32'(0));
        chk("rand_w16_drained", 32'(q16.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
